// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Grants one of two requesters (fetch I, memory-stage D) the shared
//            split request/response system bus. Optional macro
//            ARB_ROUND_ROBIN_EN alternates priority on simultaneous requests;
//            otherwise D always wins.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int RESP_BEATS     = 8
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      i_reqcyc,
  input  logic [BUS_TAG_WIDTH-1:0]  i_reqtag,
  input  logic [BUS_DATA_WIDTH-1:0] i_req,
  input  logic                      i_respack,
  output logic                      i_reqack,
  output logic                      i_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] i_resp,
  output logic [BUS_TAG_WIDTH-1:0]  i_resptag,

  input  logic                      d_reqcyc,
  input  logic [BUS_TAG_WIDTH-1:0]  d_reqtag,
  input  logic [BUS_DATA_WIDTH-1:0] d_req,
  input  logic                      d_respack,
  output logic                      d_reqack,
  output logic                      d_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] d_resp,
  output logic [BUS_TAG_WIDTH-1:0]  d_resptag,

  output logic                      bus_reqcyc,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic                      bus_respack,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

  localparam int c_cnt_w = ($clog2(RESP_BEATS) > 3) ? $clog2(RESP_BEATS) : 3;
  localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(RESP_BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t               state_q;
  owner_t               owner_q;
  logic [c_cnt_w-1:0]   beat_q;
  logic                 rd_q;
  logic                 acked_q;

  logic                      own_reqcyc;
  logic [BUS_TAG_WIDTH-1:0]  own_reqtag;
  logic [BUS_DATA_WIDTH-1:0] own_req;
  logic                      own_respack;
  logic                      resp_beat;
  logic                      any_req;
  logic                      grant_d;

  assign own_reqcyc  = (owner_q == OWN_D) ? d_reqcyc  : i_reqcyc;
  assign own_reqtag  = (owner_q == OWN_D) ? d_reqtag  : i_reqtag;
  assign own_req     = (owner_q == OWN_D) ? d_req     : i_req;
  assign own_respack = (owner_q == OWN_D) ? d_respack : i_respack;

  assign resp_beat = (state_q == ST_RESP) && bus_respcyc && own_respack;
  assign any_req   = i_reqcyc || d_reqcyc;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_q;

  // On a tie the requester that was not granted last takes the bus.
  assign grant_d = d_reqcyc && (!i_reqcyc || (last_q == OWN_I));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= OWN_I;
    end else if ((state_q == ST_IDLE) && any_req) begin
      last_q <= grant_d ? OWN_D : OWN_I;
    end
  end
`else
  assign grant_d = d_reqcyc;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_D;
      beat_q  <= '0;
      rd_q    <= 1'b0;
      acked_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            owner_q <= grant_d ? OWN_D : OWN_I;
            acked_q <= 1'b0;
            rd_q    <= 1'b0;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          // The read/write kind is taken from the tag seen with the first ack.
          if (bus_reqack && !acked_q) begin
            acked_q <= 1'b1;
            rd_q    <= own_reqtag[BUS_TAG_WIDTH-1];
          end
          if (!own_reqcyc && acked_q) begin
            state_q <= rd_q ? ST_RESP : ST_IDLE;
          end
        end
        ST_RESP: begin
          if (resp_beat) begin
            if (beat_q == c_last_beat) begin
              beat_q  <= '0;
              state_q <= ST_IDLE;
            end else begin
              beat_q <= beat_q + c_cnt_w'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_reqcyc  = 1'b0;
    bus_reqtag  = '0;
    bus_req     = '0;
    bus_respack = 1'b0;
    i_reqack    = 1'b0;
    i_respcyc   = 1'b0;
    i_resp      = '0;
    i_resptag   = '0;
    d_reqack    = 1'b0;
    d_respcyc   = 1'b0;
    d_resp      = '0;
    d_resptag   = '0;
    if (state_q == ST_REQ) begin
      bus_reqcyc = own_reqcyc;
      bus_reqtag = own_reqtag;
      bus_req    = own_req;
      if (owner_q == OWN_D) d_reqack = bus_reqack;
      else                  i_reqack = bus_reqack;
    end
    if (state_q == ST_RESP) begin
      bus_respack = own_respack;
      if (owner_q == OWN_D) begin
        d_respcyc = bus_respcyc;
        d_resp    = bus_resp;
        d_resptag = bus_resptag;
      end else begin
        i_respcyc = bus_respcyc;
        i_resp    = bus_resp;
        i_resptag = bus_resptag;
      end
    end
  end

endmodule
`default_nettype wire
